// File: rtl/matmul_drain.sv
// matmul_drain: drains the VECTOR_SIZE^2 result matrix from the Z memory as a
// valid/ready stream in row-major order, tagging the final word with out_last.
// A 2-entry output buffer hides the 1-cycle read latency of the Z memory.
module matmul_drain #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned VECTOR_SIZE = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  done,
  output logic [ADDR_WIDTH-1:0] z_rd_addr,
  input  logic [DATA_WIDTH-1:0] z_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  drain_done
);

  localparam int unsigned N  = VECTOR_SIZE * VECTOR_SIZE;
  localparam int unsigned CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WAIT_LOW
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_ia;        // next address to issue, 0..N
  logic [CW-1:0]       r_oc;        // index of the word at the buffer head
  logic                r_inflight;  // a read was issued last cycle
  logic [1:0]          r_count;     // words held in the buffer (out_data is the head)
  logic [DATA_WIDTH-1:0] r_data1;   // second buffer entry

  logic                w_hs;
  logic [1:0]          w_occ;
  logic                w_issue;
  logic                w_last_hs;
  logic [1:0]          w_cnt_after_pop;
  logic [1:0]          w_count_nxt;
  logic [CW-1:0]       w_oc_nxt;
  logic [CW-1:0]       w_ia_nxt;

  // Handshake, occupancy and read-issue decisions for this cycle.
  assign w_hs            = out_valid & out_ready;
  assign w_occ           = r_count + 2'(r_inflight);
  assign w_issue         = (r_state == S_READ) && (r_ia < CW'(N)) &&
                           ((w_occ < 2'd2) || w_hs);
  assign w_last_hs       = w_hs && (r_oc == CW'(N - 1));
  assign w_cnt_after_pop = r_count - 2'(w_hs);
  assign w_count_nxt     = w_cnt_after_pop + 2'(r_inflight);
  assign w_oc_nxt        = r_oc + CW'(w_hs);
  assign w_ia_nxt        = r_ia + CW'(w_issue);

  // Control FSM: trigger on done, drain N words, then wait for done to drop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ia       <= '0;
      r_oc       <= '0;
      z_rd_addr  <= '0;
      busy       <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (done) begin
            r_state   <= S_READ;
            r_ia      <= '0;
            r_oc      <= '0;
            z_rd_addr <= '0;
            busy      <= 1'b1;
          end
        end
        S_READ: begin
          r_ia      <= w_ia_nxt;
          r_oc      <= w_oc_nxt;
          z_rd_addr <= w_ia_nxt[ADDR_WIDTH-1:0];
          if (w_last_hs) begin
            r_state    <= S_WAIT_LOW;
            busy       <= 1'b0;
            drain_done <= 1'b1;
            z_rd_addr  <= '0;
          end
        end
        S_WAIT_LOW: begin
          if (!done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output buffer: out_data is the head entry, r_data1 the tail behind it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_data1    <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_count    <= w_count_nxt;
      out_valid  <= (w_count_nxt != 2'd0);
      out_last   <= (w_count_nxt != 2'd0) && (w_oc_nxt == CW'(N - 1));
      // A full buffer never has a read in flight, so shift and fill cannot collide.
      if (w_hs && (r_count == 2'd2)) out_data <= r_data1;
      if (r_inflight) begin
        if (w_cnt_after_pop == 2'd0) out_data <= z_dout;
        else                         r_data1  <= z_dout;
      end
    end
  end

endmodule

// File: tb/tb_matmul_drain.sv
// Directed bench for matmul_drain: Z memory model holds addr+0x1000.
module tb_matmul_drain;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;
  localparam int unsigned VS = 8;
  localparam int          N  = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          done = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] z_rd_addr;
  logic [DW-1:0] z_dout;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic          drain_done;

  int n_checks = 0;
  int n_errors = 0;

  matmul_drain #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .VECTOR_SIZE(VS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .done      (done),
    .z_rd_addr (z_rd_addr),
    .z_dout    (z_dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .drain_done(drain_done)
  );

  always #5 clock = ~clock;

  // 1-cycle synchronous-read Z memory preloaded with addr+0x1000.
  always @(posedge clock) z_dout <= 32'h1000 + 32'(z_rd_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ":z_rd_addr"},  32'(z_rd_addr),  32'd0);
    chk({tag, ":out_data"},   out_data,        32'd0);
    chk({tag, ":out_valid"},  32'(out_valid),  32'd0);
    chk({tag, ":out_last"},   32'(out_last),   32'd0);
    chk({tag, ":busy"},       32'(busy),       32'd0);
    chk({tag, ":drain_done"}, 32'(drain_done), 32'd0);
  endtask

  // Raise done and consume N words. mode 0: ready always, mode 1: 1-on/2-off.
  // ready is held low for the first 'stall' cycles after done is sampled.
  task automatic run_drain(input string name, input int mode, input int stall, input int budget);
    int idx = 0;
    int c = 0;
    bit first_seen = 1'b0;
    bit stalled = 1'b0;
    bit rdy;
    done = 1'b1;
    out_ready = 1'b0;
    while (idx < N && c < budget) begin
      @(negedge clock);
      c++;
      if (!first_seen && out_valid) begin
        first_seen = 1'b1;
        chk({name, ":first_latency"}, 32'(c), 32'd3);
      end
      if (first_seen && mode == 0) chk({name, ":valid_cont"}, 32'(out_valid), 32'd1);
      if (stalled) begin
        chk({name, ":stall_valid"}, 32'(out_valid), 32'd1);
        chk({name, ":stall_data"},  out_data, 32'h1000 + 32'(idx));
      end
      if (stall > 0 && c == stall) begin
        chk({name, ":bp_valid"}, 32'(out_valid), 32'd1);
        chk({name, ":bp_data"},  out_data, 32'h1000);
        chk({name, ":bp_addr"},  32'(z_rd_addr), 32'd2);
      end
      if (out_valid) chk({name, ":last"}, 32'(out_last), 32'(idx == N - 1));
      rdy = (c <= stall) ? 1'b0 : ((mode == 1) ? ((c % 3) == 0) : 1'b1);
      out_ready = rdy;
      if (out_valid && rdy) begin
        chk({name, ":word"}, out_data, 32'h1000 + 32'(idx));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = out_valid;
      end
    end
    if (idx < N) chk({name, ":timeout_words"}, 32'(idx), 32'(N));
    if (mode == 0 && stall == 0) chk({name, ":final_edge"}, 32'(c), 32'd66);
    @(negedge clock);
    chk({name, ":drain_done_pulse"}, 32'(drain_done), 32'd1);
    chk({name, ":busy_after"},       32'(busy),       32'd0);
    chk({name, ":valid_after"},      32'(out_valid),  32'd0);
    @(negedge clock);
    chk({name, ":drain_done_clear"}, 32'(drain_done), 32'd0);
  endtask

  initial begin
    int bad;
    int acc;
    int c;

    // Power-on reset
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    chk_all_zero("rst");
    reset = 1'b0;
    @(negedge clock);
    chk("idle_busy", 32'(busy), 32'd0);

    // Full-throughput drain, then done held high: no re-trigger
    run_drain("t1", 0, 0, 200);
    bad = 0;
    repeat (200) begin
      @(negedge clock);
      if (busy || out_valid || (z_rd_addr != '0)) bad++;
    end
    chk("hold_no_retrigger", 32'(bad), 32'd0);
    done = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_after_t1", 32'(busy), 32'd0);

    // Second drain after done falls and rises again, 1-on/2-off ready
    run_drain("t2", 1, 0, 400);
    done = 1'b0;
    repeat (2) @(negedge clock);

    // Backpressure for 10 cycles after done is sampled
    run_drain("t3", 0, 10, 200);
    done = 1'b0;
    repeat (2) @(negedge clock);

    // Reset once word 20 has been accepted
    done = 1'b1;
    out_ready = 1'b1;
    acc = 0;
    c = 0;
    while (acc < 21 && c < 200) begin
      @(negedge clock);
      c++;
      if (out_valid) begin
        chk("t4:pre_word", out_data, 32'h1000 + 32'(acc));
        acc++;
      end
    end
    chk("t4:pre_count", 32'(acc), 32'd21);
    @(posedge clock);
    #2 reset = 1'b1;
    done = 1'b0;
    #1 chk_all_zero("t4:async_rst");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_drain("t5", 0, 0, 200);
    done = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
